mem_copy_engine: RTL and testbench

- Bus initiator for the 8-bit processor's data memory: copies a block of bytes or fills a block with a constant, on behalf of the CPU.
- Drives the memory-side signals `mem_read`, `mem_write`, `addr` and `write_data`, and samples `read_data`.
- Assumes memory read data is combinational while `mem_read` is high, and memory writes commit at the posedge of `clk`.
- Sits beside the CPU. When `busy` is high it owns the memory port; an external mux selects it.

---
 rtl/mem_copy_engine.sv | 160 ++++++++++++++++
 tb/tb_mem_copy_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Memory copy/fill engine: bus initiator that copies a block of bytes or
// fills a block with a constant on behalf of the CPU.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bytes_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] idx_inc;
  logic [ADDR_W-1:0] cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              busy_d, done_d, rd_d, wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign idx_inc = idx_q + ADDR_W'(1);

  // Next-state, datapath and next-output decode; outputs follow the next state
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cnt_d   = bytes_done;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;

    case (state_q)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          mode_d = mode;
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = length;
          fill_d = fill_value;
          idx_d  = '0;
          cnt_d  = '0;
          if (length == '0) begin
            state_d = DONE;
          end else if (mode) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        buf_d   = mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_inc;
        cnt_d = bytes_done + ADDR_W'(1);
        if (idx_inc == len_q) begin
          state_d = DONE;
        end else if (mode_q) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A write in the abort cycle still commits and is counted above
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    rd_d   = (state_d == READ);
    wr_d   = (state_d == WRITE);
    if (rd_d) begin
      addr_d = src_d + idx_d;
    end
    if (wr_d) begin
      addr_d  = dst_d + idx_d;
      wdata_d = mode_d ? fill_d : buf_d;
    end
  end

  // State, datapath and registered output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      idx_q      <= '0;
      buf_q      <= '0;
      bytes_done <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      bytes_done <= cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      mem_read   <= rd_d;
      mem_write  <= wr_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed cases plus randomized
// copy/fill operations checked against a transaction-level reference model.
module tb_mem_copy_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic [7:0] fill_value;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] bytes_done;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem      [256];
  logic [7:0] init_mem [256];
  logic       load;

  // Expected bus trace of one operation: one entry per busy access cycle
  logic       acc_rd   [512];
  logic [7:0] acc_addr [512];
  logic [7:0] acc_data [512];
  logic [7:0] exp_mem  [256];

  int n_checks;
  int n_fail;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bytes_done (bytes_done),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge, bulk preload
  assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
  endtask

  // Runs one operation; ab = cycle in which abort is raised (0 = none),
  // ign = cycle in which a conflicting start is raised (0 = none).
  task automatic run_op(input logic md, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] n, input logic [7:0] f,
                        input int ab, input int ign);
    logic [7:0] sm [256];
    logic [7:0] v;
    int nacc, k, nwr, end_c, ndiff;

    // Reference: forward byte-by-byte transfer over a scratch memory
    for (int i = 0; i < 256; i++) sm[i] = init_mem[i];
    nacc = 0;
    for (int i = 0; i < int'(n); i++) begin
      if (md) begin
        v = f;
      end else begin
        v = sm[8'(int'(s) + i)];
        acc_rd[nacc] = 1'b1; acc_addr[nacc] = 8'(int'(s) + i); acc_data[nacc] = 8'h00;
        nacc++;
      end
      sm[8'(int'(d) + i)] = v;
      acc_rd[nacc] = 1'b0; acc_addr[nacc] = 8'(int'(d) + i); acc_data[nacc] = v;
      nacc++;
    end
    k = (ab != 0) ? ab : nacc;
    nwr = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_mem[i];
    for (int j = 0; j < k; j++) begin
      if (!acc_rd[j]) begin
        exp_mem[acc_addr[j]] = acc_data[j];
        nwr++;
      end
    end
    end_c = (ab != 0) ? ab + 1 : nacc + 2;

    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;

    @(negedge clk);
    start = 1'b1; mode = md; src_addr = s; dst_addr = d; length = n; fill_value = f;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'($urandom); src_addr = 8'($urandom); dst_addr = 8'($urandom);
    length = 8'($urandom); fill_value = 8'($urandom);

    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      if (c <= k) begin
        check("busy_op", 32'(busy), 32'd1);
        check("done_op", 32'(done), 32'd0);
        check("rd", 32'(mem_read), 32'(acc_rd[c-1]));
        check("wr", 32'(mem_write), 32'(!acc_rd[c-1]));
        check("addr", 32'(mem_addr), 32'(acc_addr[c-1]));
        if (!acc_rd[c-1]) check("wdata", 32'(mem_wdata), 32'(acc_data[c-1]));
      end else if (ab == 0 && c == nacc + 1) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd1);
        check("rd_done", 32'(mem_read), 32'd0);
        check("wr_done", 32'(mem_write), 32'd0);
      end else begin
        check("busy_idle", 32'(busy), 32'd0);
        check("done_idle", 32'(done), 32'd0);
        check("rd_idle", 32'(mem_read), 32'd0);
        check("wr_idle", 32'(mem_write), 32'd0);
      end
      check("rw_excl", 32'(mem_read && mem_write), 32'd0);
      check("done_acc", 32'(done && (mem_read || mem_write)), 32'd0);
      if (c == ab) abort = 1'b1;
      if (c == ign) begin
        start = 1'b1; mode = 1'($urandom); src_addr = 8'($urandom);
        dst_addr = 8'($urandom); length = 8'($urandom_range(1, 255));
        fill_value = 8'($urandom);
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
    end

    check("bytes_done", 32'(bytes_done), 32'(nwr));
    ndiff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) ndiff++;
    check("mem_diff", 32'(ndiff), 32'd0);
    for (int i = 0; i < 256; i++) init_mem[i] = mem[i];
  endtask

  initial begin
    int md, n, nacc_est, ab, ign;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0; abort = 1'b0; load = 1'b0;
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(bytes_done), 32'd0);
    check("rst_rd", 32'(mem_read), 32'd0);
    check("rst_wr", 32'(mem_write), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed copy of four bytes
    randomize_mem();
    init_mem[8'h10] = 8'hA1; init_mem[8'h11] = 8'hB2;
    init_mem[8'h12] = 8'hC3; init_mem[8'h13] = 8'hD4;
    run_op(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 0, 0);
    check("copy_b0", 32'(mem[8'h40]), 32'h A1);
    check("copy_b3", 32'(mem[8'h43]), 32'h D4);
    // Fill with address wrap
    run_op(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5A, 0, 0);
    check("fill_wrap", 32'(mem[8'h00]), 32'h5A);
    // Zero length
    run_op(1'b0, 8'h20, 8'h30, 8'd0, 8'h00, 0, 0);
    // Abort in cycle 5 of an 8-byte copy
    randomize_mem();
    run_op(1'b0, 8'h80, 8'hC0, 8'd8, 8'h00, 5, 0);
    // Ignored start in cycle 3 of a 2-byte copy
    run_op(1'b0, 8'h05, 8'h09, 8'd2, 8'h00, 0, 3);
    // Overlapping forward copy and source-address wrap
    run_op(1'b0, 8'h50, 8'h52, 8'd6, 8'h00, 0, 0);
    run_op(1'b0, 8'hFE, 8'h60, 8'd4, 8'h00, 0, 0);

    // Randomized operations
    for (int t = 0; t < 40; t++) begin
      md = int'($urandom_range(0, 1));
      n = (t == 5 || t == 6) ? 255 : int'($urandom_range(0, 20));
      nacc_est = (md != 0) ? n : 2 * n;
      ab = 0; ign = 0;
      if (nacc_est > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, nacc_est));
      if ($urandom_range(0, 3) == 0)
        ign = int'($urandom_range(1, (ab != 0) ? ab : nacc_est + 1));
      if (t % 4 == 0) randomize_mem();
      run_op(1'(md), 8'($urandom), 8'($urandom), 8'(n), 8'($urandom), ab, ign);
    end

    // Asynchronous reset in the middle of a copy
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = 8'h10; dst_addr = 8'h90; length = 8'd8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cnt", 32'(bytes_done), 32'd0);
    check("arst_rd", 32'(mem_read), 32'd0);
    check("arst_wr", 32'(mem_write), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 256; i++) init_mem[i] = mem[i];
    run_op(1'b1, 8'h00, 8'h70, 8'd5, 8'hC3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
